sprite_attr_shadow_mem: RTL and testbench
=========================================

Name: sprite_attr_shadow_mem

Overview:
- Parametrised sprite-attribute store with a CPU-side shadow bank and a renderer-side active bank.
- CPU byte-lane writes go to the shadow bank only; a per-entry dirty bitmap tracks modified sprites.
- On a commit request (issued by the display controller in vblank), a copy engine transfers dirty entries from shadow to active, one entry per clock.
- The renderer reads the active bank by sprite index, so it never sees a half-updated sprite during a frame.

Parameters:
- NUM_SPRITES, 32, number of sprite entries; power of two, 2..256.
- ENTRY_WORDS, 2, 32-bit words per entry; power of two, 1..8.
- BASE_ADDR, 27'h100, byte address of entry 0 word 0 in CPU space.
- IDX_W, $clog2(NUM_SPRITES), sprite index width (derived).
- ENTRY_W, 32*ENTRY_WORDS, entry width in bits (derived).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_spirit_idx  in  IDX_W  renderer read index into the active bank.
- o_spirit_struct  out  ENTRY_W  active-bank entry, registered.
- i_wdata  in  32  CPU write data.
- i_wea  in  1  CPU write enable.
- i_wselect  in  4  byte-lane enables; bit n enables i_wdata[8n+7:8n].
- i_waddr  in  27  CPU byte address.
- i_commit  in  1  single-cycle commit request.
- o_busy  out  1  high while the copy engine is in COPY.
- o_commit_done  out  1  one-cycle pulse when a commit completes.

Behaviour:
- Reset, asserted asynchronously: all shadow/active words = 0, dirty bitmap = 0, state = IDLE, o_spirit_struct = 0, o_busy = 0, o_commit_done = 0. Reset mid-COPY aborts the copy; no done pulse.
- Write decode:
  - off = i_waddr - BASE_ADDR, computed at 27 bits.
  - The write is accepted iff i_wea = 1, i_waddr >= BASE_ADDR, and off < NUM_SPRITES*ENTRY_WORDS*4.
  - word = off[..:2]; sprite s = word / ENTRY_WORDS; lane = word % ENTRY_WORDS. Word 0 occupies bits [31:0] (little-endian words).
  - off[1:0] is ignored.
  - Accepted writes update the enabled bytes of shadow[s][lane] and set dirty[s], even when i_wselect = 0.
  - Rejected writes change nothing.
- Read port:
  - o_spirit_struct <= active[i_spirit_idx] every cycle; one-cycle latency.
  - If the active entry is written in the same cycle, the old value is returned.
- State machine, states IDLE and COPY:
  - IDLE, i_commit = 1, dirty != 0: go to COPY, ptr = 0.
  - IDLE, i_commit = 1, dirty == 0: stay in IDLE and pulse o_commit_done on the next cycle.
  - COPY, each cycle: if dirty[ptr], then active[ptr] <= shadow[ptr] (value before any same-cycle CPU write) and dirty[ptr] is cleared. Then ptr increments.
  - COPY lasts exactly NUM_SPRITES cycles regardless of the dirty count. After ptr = NUM_SPRITES-1 the block returns to IDLE, o_busy drops, and o_commit_done pulses that cycle.
  - o_busy = (state == COPY), registered.
  - i_commit while in COPY is ignored (not queued).
- CPU writes during COPY are always accepted.
  - Same-cycle write to sprite ptr: the copy takes the old shadow value, and dirty[ptr] stays set (set beats clear).
  - Write to a sprite already passed by ptr: stays dirty until the next commit.

Test Plan:
1. Reset; write 0x100 sel=F 0x11223344, then 0x104 sel=F 0x55667788; commit; wait for done; idx=0 -> o_spirit_struct=64'h5566778811223344 one cycle after idx is applied.
2. Shadow isolation: write 0x108 = 0xAAAAAAAA with no commit -> active idx 1 reads 0. Then write 0x108 sel=4'b0010 data 0x0000BB00 and commit -> idx 1 = 64'h00000000AAAABBAA.
3. Out-of-range: writes to 0x0FC and to 0x200 (NUM_SPRITES=32, ENTRY_WORDS=2), then commit -> no dirty bits set, o_commit_done one cycle after the commit, o_busy never high.
4. Timing: dirty[3] only; commit at cycle T -> o_busy high for cycles T+1..T+32, o_commit_done at the cycle o_busy falls; a second i_commit at T+5 has no effect.
5. Collision: during COPY, write sprite 7 in the cycle ptr=7 -> active[7] holds the pre-write value. The next commit copies the new value.
6. Reset mid-COPY (ptr=10): all outputs 0 immediately; the active bank reads 0 after release.

Source files
------------

// File: rtl/sprite_attr_shadow_mem.sv
// Double-buffered sprite attribute store: CPU writes land in a shadow bank and a
// commit-time copy engine moves dirty entries into the bank the renderer reads.

module sprite_attr_entry #(
   parameter int ENTRY_WORDS = 2,
   parameter int LANE_W      = 1,
   parameter int ENTRY_W     = 32*ENTRY_WORDS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [LANE_W-1:0] wr_lane,
   input  logic [3:0]        wsel,
   input  logic [31:0]       wdata,
   input  logic              copy_en,
   output logic [ENTRY_W-1:0] active,
   output logic              dirty
);

   logic [ENTRY_WORDS-1:0][31:0] shadow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow <= '0;
         active <= '0;
         dirty  <= 1'b0;
      end else begin
         for (int w = 0; w < ENTRY_WORDS; w++)
            for (int b = 0; b < 4; b++)
               if (wr_en && wr_lane == LANE_W'(w) && wsel[b])
                  shadow[w][8*b +: 8] <= wdata[8*b +: 8];
         // copy sees the pre-write shadow; a same-cycle write keeps the entry dirty
         if (copy_en && dirty)
            active <= shadow;
         dirty <= wr_en | (dirty & ~copy_en);
      end
   end

endmodule

module sprite_attr_shadow_mem #(
   parameter int          NUM_SPRITES = 32,
   parameter int          ENTRY_WORDS = 2,
   parameter logic [26:0] BASE_ADDR   = 27'h100,
   parameter int          IDX_W       = $clog2(NUM_SPRITES),
   parameter int          ENTRY_W     = 32*ENTRY_WORDS
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [IDX_W-1:0]   i_spirit_idx,
   output logic [ENTRY_W-1:0] o_spirit_struct,
   input  logic [31:0]        i_wdata,
   input  logic               i_wea,
   input  logic [3:0]         i_wselect,
   input  logic [26:0]        i_waddr,
   input  logic               i_commit,
   output logic               o_busy,
   output logic               o_commit_done
);

   localparam int          LANE_W = (ENTRY_WORDS > 1) ? $clog2(ENTRY_WORDS) : 1;
   localparam logic [26:0] SPAN   = 27'(NUM_SPRITES*ENTRY_WORDS*4);

   typedef enum logic {IDLE, COPY} state_t;

   typedef struct packed {
      logic              vld;
      logic [IDX_W-1:0]  spr;
      logic [LANE_W-1:0] lane;
   } wreq_t;

   state_t     state;
   logic [IDX_W-1:0] ptr;
   logic [26:0] off;
   logic [24:0] word;
   wreq_t       wreq;
   logic        unused_off;

   logic [NUM_SPRITES-1:0]              dirty;
   logic [NUM_SPRITES-1:0]              copy_en;
   logic [NUM_SPRITES-1:0][ENTRY_W-1:0] active_all;

   assign unused_off = ^off[1:0];

   always_comb begin
      off       = i_waddr - BASE_ADDR;
      word      = off[26:2];
      wreq.vld  = i_wea && (i_waddr >= BASE_ADDR) && (off < SPAN);
      wreq.spr  = IDX_W'(word / ENTRY_WORDS);
      wreq.lane = LANE_W'(word % ENTRY_WORDS);
   end

   for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_ent
      assign copy_en[g] = (state == COPY) && (ptr == IDX_W'(g));

      sprite_attr_entry #(
         .ENTRY_WORDS(ENTRY_WORDS),
         .LANE_W     (LANE_W),
         .ENTRY_W    (ENTRY_W)
      ) u_ent (
         .clk    (clk),
         .rst_n  (rst_n),
         .wr_en  (wreq.vld && wreq.spr == IDX_W'(g)),
         .wr_lane(wreq.lane),
         .wsel   (i_wselect),
         .wdata  (i_wdata),
         .copy_en(copy_en[g]),
         .active (active_all[g]),
         .dirty  (dirty[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         ptr           <= '0;
         o_busy        <= 1'b0;
         o_commit_done <= 1'b0;
      end else begin
         o_commit_done <= 1'b0;
         case (state)
            IDLE: begin
               if (i_commit) begin
                  if (|dirty) begin
                     state  <= COPY;
                     ptr    <= '0;
                     o_busy <= 1'b1;
                  end else begin
                     o_commit_done <= 1'b1;
                  end
               end
            end
            COPY: begin
               // full sweep every commit keeps the busy window a fixed length
               ptr <= ptr + 1'b1;
               if (ptr == IDX_W'(NUM_SPRITES-1)) begin
                  state         <= IDLE;
                  o_busy        <= 1'b0;
                  o_commit_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) o_spirit_struct <= '0;
      else        o_spirit_struct <= active_all[i_spirit_idx];
   end

endmodule

// File: tb/tb_sprite_attr_shadow_mem.sv
// Bench for sprite_attr_shadow_mem: vector table, timing/collision/reset sequences,
// and random traffic against an array-based model of the two banks.

module tb_sprite_attr_shadow_mem;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  i_spirit_idx = '0;
   logic [63:0] o_spirit_struct;
   logic [31:0] i_wdata = '0;
   logic        i_wea = 1'b0;
   logic [3:0]  i_wselect = '0;
   logic [26:0] i_waddr = '0;
   logic        i_commit = 1'b0;
   logic        o_busy;
   logic        o_commit_done;

   int checks = 0;
   int errors = 0;

   logic [63:0] m_shadow [32];
   logic [63:0] m_active [32];
   bit          m_dirty  [32];

   sprite_attr_shadow_mem dut (
      .clk(clk), .rst_n(rst_n), .i_spirit_idx(i_spirit_idx), .o_spirit_struct(o_spirit_struct),
      .i_wdata(i_wdata), .i_wea(i_wea), .i_wselect(i_wselect), .i_waddr(i_waddr),
      .i_commit(i_commit), .o_busy(o_busy), .o_commit_done(o_commit_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic void m_clear();
      for (int i = 0; i < 32; i++) begin
         m_shadow[i] = '0; m_active[i] = '0; m_dirty[i] = 0;
      end
   endfunction

   function automatic void m_write(input logic [26:0] a, input logic [3:0] s, input logic [31:0] d);
      int off, spr, lane;
      if (a < 27'h100 || a >= 27'h200) return;
      off  = int'(a) - 'h100;
      spr  = off / 8;
      lane = (off / 4) % 2;
      for (int b = 0; b < 4; b++)
         if (s[b]) m_shadow[spr][lane*32 + b*8 +: 8] = d[b*8 +: 8];
      m_dirty[spr] = 1;
   endfunction

   function automatic bit m_any_dirty();
      for (int i = 0; i < 32; i++) if (m_dirty[i]) return 1;
      return 0;
   endfunction

   function automatic void m_commit();
      for (int i = 0; i < 32; i++)
         if (m_dirty[i]) begin
            m_active[i] = m_shadow[i];
            m_dirty[i]  = 0;
         end
   endfunction

   task automatic cpu_write(input logic [26:0] a, input logic [3:0] s, input logic [31:0] d);
      i_waddr = a; i_wselect = s; i_wdata = d; i_wea = 1'b1;
      @(posedge clk); #1;
      i_wea = 1'b0;
      m_write(a, s, d);
   endtask

   task automatic commit_pulse();
      i_commit = 1'b1;
      @(posedge clk); #1;
      i_commit = 1'b0;
      m_commit();
   endtask

   task automatic commit_wait(input string nm);
      int n, nbusy, exp_n;
      exp_n = m_any_dirty() ? 32 : 0;
      commit_pulse();
      n = 0; nbusy = 0;
      while (!o_commit_done && n < 100) begin
         if (o_busy) nbusy++;
         @(posedge clk); #1;
         n++;
      end
      check({nm, "_done_lat"}, 64'(n), 64'(exp_n));
      check({nm, "_busy_cyc"}, 64'(nbusy), 64'(exp_n));
      check({nm, "_busy_at_done"}, 64'(o_busy), 64'd0);
   endtask

   task automatic read(input int idx, output logic [63:0] v);
      i_spirit_idx = 5'(idx);
      @(posedge clk); #1;
      v = o_spirit_struct;
   endtask

   typedef struct {
      logic [26:0] addr;
      logic [3:0]  sel;
      logic [31:0] data;
      bit          do_commit;
      int          idx;
      logic [63:0] exp;
   } vec_t;

   vec_t vt [9];

   initial begin
      logic [63:0] v;
      int n;

      vt[0] = '{27'h100, 4'hF, 32'h11223344, 0, 0,  64'h0};
      vt[1] = '{27'h104, 4'hF, 32'h55667788, 1, 0,  64'h55667788_11223344};
      vt[2] = '{27'h108, 4'hF, 32'hAAAAAAAA, 0, 1,  64'h0};
      vt[3] = '{27'h108, 4'h2, 32'h0000BB00, 1, 1,  64'h00000000_AAAABBAA};
      vt[4] = '{27'h0FC, 4'hF, 32'hFFFFFFFF, 1, 31, 64'h0};
      vt[5] = '{27'h200, 4'hF, 32'hFFFFFFFF, 1, 0,  64'h55667788_11223344};
      vt[6] = '{27'h1FF, 4'h8, 32'hDE000000, 1, 31, 64'hDE000000_00000000};
      vt[7] = '{27'h10B, 4'h1, 32'h000000CC, 1, 1,  64'h00000000_AAAABBCC};
      vt[8] = '{27'h110, 4'h0, 32'hFFFFFFFF, 1, 2,  64'h0};

      m_clear();
      #12;
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_done", 64'(o_commit_done), 64'd0);
      check("rst_struct", o_spirit_struct, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      read(5, v);
      check("rst_read5", v, 64'd0);

      for (int i = 0; i < 9; i++) begin
         cpu_write(vt[i].addr, vt[i].sel, vt[i].data);
         if (vt[i].do_commit) commit_wait($sformatf("vec%0d", i));
         read(vt[i].idx, v);
         check($sformatf("vec%0d_read", i), v, vt[i].exp);
      end

      // fixed 32-cycle busy window; commit during COPY is ignored
      cpu_write(27'h118, 4'hF, 32'hCAFEF00D);
      commit_pulse();
      for (int k = 1; k <= 32; k++) begin
         check($sformatf("tim_busy%0d", k), 64'(o_busy), 64'd1);
         check($sformatf("tim_done%0d", k), 64'(o_commit_done), 64'd0);
         i_commit = (k == 4);
         @(posedge clk); #1;
      end
      i_commit = 1'b0;
      check("tim_busy_fall", 64'(o_busy), 64'd0);
      check("tim_done_pulse", 64'(o_commit_done), 64'd1);
      @(posedge clk); #1;
      check("tim_done_once", 64'(o_commit_done), 64'd0);
      check("tim_no_requeue", 64'(o_busy), 64'd0);
      read(3, v);
      check("tim_read3", v, m_active[3]);

      // write sprite 7 in the exact cycle the copy pointer visits it
      cpu_write(27'h138, 4'hF, 32'h77777777);
      commit_pulse();
      repeat (7) begin @(posedge clk); #1; end
      cpu_write(27'h138, 4'hF, 32'h12345678);
      n = 0;
      while (!o_commit_done && n < 60) begin @(posedge clk); #1; n++; end
      check("col_done_seen", 64'(o_commit_done), 64'd1);
      read(7, v);
      check("col_old_value", v, 64'h00000000_77777777);
      commit_wait("col_recommit");
      read(7, v);
      check("col_new_value", v, 64'h00000000_12345678);

      for (int it = 0; it < 300; it++) begin
         int op;
         op = $urandom_range(0, 9);
         if (op < 6)
            cpu_write(27'h0F0 + 27'($urandom_range(0, 'h120)), 4'($urandom_range(0, 15)), $urandom);
         else if (op < 7)
            commit_wait($sformatf("rnd%0d_commit", it));
         else begin
            int idx;
            idx = $urandom_range(0, 31);
            read(idx, v);
            check($sformatf("rnd%0d_read%0d", it, idx), v, m_active[idx]);
         end
      end
      commit_wait("rnd_final_commit");
      for (int i = 0; i < 32; i++) begin
         read(i, v);
         check($sformatf("rnd_final_read%0d", i), v, m_active[i]);
      end

      // reset in the middle of a copy
      cpu_write(27'h160, 4'hF, 32'h0BADBEEF);
      i_spirit_idx = 5'd0;
      commit_pulse();
      repeat (10) begin @(posedge clk); #1; end
      check("mid_busy_pre", 64'(o_busy), 64'd1);
      check("mid_struct_pre", o_spirit_struct, m_active[0]);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 64'(o_busy), 64'd0);
      check("mid_rst_done", 64'(o_commit_done), 64'd0);
      check("mid_rst_struct", o_spirit_struct, 64'd0);
      m_clear();
      @(posedge clk); #1;
      rst_n = 1'b1;
      read(0, v);
      check("post_rst_read0", v, 64'd0);
      check("post_rst_done", 64'(o_commit_done), 64'd0);
      read(12, v);
      check("post_rst_read12", v, 64'd0);
      check("post_rst_busy", 64'(o_busy), 64'd0);
      commit_wait("post_rst_commit");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
